// File: rtl/lap_stopwatch_if.sv
// Pin bundle between the board's button debouncers / segment decoders and lap_stopwatch.
// Inputs are synchronous levels and every output is valid on every cycle; there is no valid/ready handshake.
interface lap_stopwatch_if #(
   parameter int DIGITS = 4
);
   logic                  start_stop;
   logic                  lap;
   logic                  clear;
   logic [4*DIGITS-1:0]   disp;
   logic [4*DIGITS-1:0]   live;
   logic                  running;
   logic                  frozen;
   logic                  ovf;
   logic [1:0]            state_dbg;

   modport master (
      output start_stop, lap, clear,
      input  disp, live, running, frozen, ovf, state_dbg
   );

   modport slave (
      input  start_stop, lap, clear,
      output disp, live, running, frozen, ovf, state_dbg
   );
endinterface

// File: rtl/lap_stopwatch.sv
// BCD stopwatch with prescaler, start/stop, lap freeze and clear.
// Define LAP_STOPWATCH_AUTOSTOP_EN to halt at all 9s on overflow instead of wrapping.
module lap_stopwatch #(
   parameter int DIGITS = 4,
   parameter int DIV    = 500000
) (
   input  logic            clk,
   input  logic            nrst,
   lap_stopwatch_if.slave  bus
);
   localparam int W  = 4 * DIGITS;
   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVF  = 2'd2
   } state_t;

   state_t          state, state_n;
   logic            ss_q, lap_q;
   logic [PW-1:0]   presc, presc_n;
   logic [W-1:0]    digits, digits_n;
   logic [W-1:0]    lap_reg, lap_n;
   logic [W-1:0]    disp_r, disp_n;
   logic            frozen, frozen_n;
   logic            ovf, ovf_n;

   logic            ss_edge, lap_edge, tick;
   logic [W-1:0]    digits_inc;
   logic [DIGITS:0] carry;

   assign ss_edge  = bus.start_stop & ~ss_q;
   assign lap_edge = bus.lap & ~lap_q;
   assign tick     = (state == ST_RUN) && (presc == PRESC_LAST);

   // Ripple increment: a digit rolls 9 -> 0 and passes the carry upward.
   assign carry[0] = 1'b1;
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] d;
      assign d = digits[4*i +: 4];
      assign digits_inc[4*i +: 4] = carry[i] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
      assign carry[i+1] = carry[i] & (d == 4'd9);
   end

   always_comb begin
      state_n  = state;
      presc_n  = presc;
      digits_n = digits;
      lap_n    = lap_reg;
      frozen_n = frozen;
      ovf_n    = ovf;

      if (bus.clear) begin
         state_n  = ST_STOP;
         presc_n  = '0;
         digits_n = '0;
         lap_n    = '0;
         frozen_n = 1'b0;
         ovf_n    = 1'b0;
      end else begin
         case (state)
            ST_STOP: begin
               if (ss_edge) begin
                  state_n = ST_RUN;
                  presc_n = '0;
               end
            end
            ST_RUN: begin
               presc_n = tick ? '0 : presc + PW'(1);
               if (tick) begin
                  digits_n = digits_inc;
                  if (carry[DIGITS]) begin
                     ovf_n = 1'b1;
`ifdef LAP_STOPWATCH_AUTOSTOP_EN
                     digits_n = digits;
                     state_n  = ST_OVF;
`endif
                  end
               end
               // A stop edge still lets a coincident tick count first.
               if (ss_edge && (state_n == ST_RUN)) begin
                  state_n = ST_STOP;
               end
            end
            default: begin
               state_n = state;
            end
         endcase

         if (lap_edge) begin
            if (frozen) begin
               frozen_n = 1'b0;
            end else begin
               lap_n    = digits;
               frozen_n = 1'b1;
            end
         end
      end

      disp_n = frozen_n ? lap_n : digits_n;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= ST_STOP;
         ss_q    <= 1'b0;
         lap_q   <= 1'b0;
         presc   <= '0;
         digits  <= '0;
         lap_reg <= '0;
         disp_r  <= '0;
         frozen  <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state   <= state_n;
         ss_q    <= bus.start_stop;
         lap_q   <= bus.lap;
         presc   <= presc_n;
         digits  <= digits_n;
         lap_reg <= lap_n;
         disp_r  <= disp_n;
         frozen  <= frozen_n;
         ovf     <= ovf_n;
      end
   end

   assign bus.disp      = disp_r;
   assign bus.live      = digits;
   assign bus.running   = (state == ST_RUN);
   assign bus.frozen    = frozen;
   assign bus.ovf       = ovf;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: integer-count reference model feeding a per-cycle scoreboard,
// directed scenarios followed by randomized button activity.
module tb_lap_stopwatch;
   localparam int DIGITS = 2;
   localparam int DIV    = 4;
   localparam int W      = 4 * DIGITS;
   localparam int EW     = 2 * W + 3;
   localparam int MAXV   = 10 ** DIGITS - 1;

   logic clk;
   logic nrst;

   lap_stopwatch_if #(.DIGITS(DIGITS)) bus ();

   lap_stopwatch #(.DIGITS(DIGITS), .DIV(DIV)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running, required finished");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   // reference model: count kept as a plain integer, converted to BCD on output
   int m_count, m_phase, m_lapv, m_mode, old_count;
   bit m_frozen, m_ovf, m_ss_prev, m_lap_prev, ss_e, lp_e;
   logic [EW-1:0] sb_exp, sb_act;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input bit s, input bit l, input bit c);
      bus.start_stop = s;
      bus.lap        = l;
      bus.clear      = c;
      @(negedge clk);
      bus.start_stop = 1'b0;
      bus.lap        = 1'b0;
      bus.clear      = 1'b0;
   endtask

   task automatic model_reset();
      m_count = 0; m_phase = 0; m_lapv = 0; m_mode = 0;
      m_frozen = 0; m_ovf = 0; m_ss_prev = 0; m_lap_prev = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      ss_e = bus.start_stop && !m_ss_prev;
      lp_e = bus.lap && !m_lap_prev;
      m_ss_prev  = bus.start_stop;
      m_lap_prev = bus.lap;
      old_count  = m_count;
      if (bus.clear) begin
         m_count = 0; m_phase = 0; m_lapv = 0; m_mode = 0; m_frozen = 0; m_ovf = 0;
      end else begin
         if (m_mode == 1) begin
            if (m_phase == DIV - 1) begin
               m_phase = 0;
               if (m_count == MAXV) begin
                  m_ovf = 1;
`ifdef LAP_STOPWATCH_AUTOSTOP_EN
                  m_mode = 2;
`else
                  m_count = 0;
`endif
               end else begin
                  m_count = m_count + 1;
               end
            end else begin
               m_phase = m_phase + 1;
            end
            if (ss_e && m_mode == 1) m_mode = 0;
         end else if (m_mode == 0 && ss_e) begin
            m_mode  = 1;
            m_phase = 0;
         end
         if (lp_e) begin
            if (m_frozen) begin
               m_frozen = 0;
            end else begin
               m_lapv   = old_count;
               m_frozen = 1;
            end
         end
      end
      exp_q.push_back({to_bcd(m_frozen ? m_lapv : m_count), to_bcd(m_count),
                       (m_mode == 1), m_frozen, m_ovf});
   endtask

   // ---------------- main ----------------
   initial begin
      bus.start_stop = 1'b0;
      bus.lap        = 1'b0;
      bus.clear      = 1'b0;
      nrst           = 1'b1;
      model_reset();

      fork
         forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) model_reset();
            else       model_step();
         end
         forever begin
            @(negedge clk);
            if (nrst && exp_q.size() != 0) begin
               sb_exp = exp_q.pop_front();
               sb_act = {bus.disp, bus.live, bus.running, bus.frozen, bus.ovf};
               check("scoreboard", 32'(sb_act), 32'(sb_exp));
            end
         end
      join_none

      // reset state
      #1 nrst = 1'b0;
      #1;
      check("reset_disp",    32'(bus.disp),    32'h0);
      check("reset_live",    32'(bus.live),    32'h0);
      check("reset_running", 32'(bus.running), 32'h0);
      check("reset_frozen",  32'(bus.frozen),  32'h0);
      check("reset_ovf",     32'(bus.ovf),     32'h0);
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      step(2);

      // start and count 40 cycles
      pulse(0, 0, 1);
      pulse(1, 0, 0);
      step(39);
      check("count39_live", 32'(bus.live), 32'h09);
      step(1);
      check("count40_live", 32'(bus.live), 32'h10);
      check("count40_running", 32'(bus.running), 32'h1);

      // lap freeze at 0x07
      pulse(0, 0, 1);
      pulse(1, 0, 0);
      step(29);
      check("lap_pre_live", 32'(bus.live), 32'h07);
      pulse(0, 1, 0);
      step(8);
      check("lap_disp", 32'(bus.disp), 32'h07);
      check("lap_live", 32'(bus.live), 32'h09);
      check("lap_frozen", 32'(bus.frozen), 32'h1);
      pulse(0, 1, 0);
      check("unlap_disp", 32'(bus.disp), 32'(bus.live));
      check("unlap_disp_val", 32'(bus.disp), 32'h09);

      // stop at prescaler 2, restart, first increment a full period later
      pulse(0, 0, 1);
      pulse(1, 0, 0);
      step(1);
      pulse(1, 0, 0);
      check("stop_running", 32'(bus.running), 32'h0);
      step(3);
      pulse(1, 0, 0);
      check("restart_running", 32'(bus.running), 32'h1);
      step(3);
      check("restart_3cyc_live", 32'(bus.live), 32'h00);
      step(1);
      check("restart_4cyc_live", 32'(bus.live), 32'h01);

      // overflow past 0x99
      pulse(0, 0, 1);
      pulse(1, 0, 0);
      step(399);
      check("pre_ovf_live", 32'(bus.live), 32'h99);
      check("pre_ovf_flag", 32'(bus.ovf), 32'h0);
      step(1);
      check("ovf_flag", 32'(bus.ovf), 32'h1);
`ifdef LAP_STOPWATCH_AUTOSTOP_EN
      check("ovf_live_hold", 32'(bus.live), 32'h99);
      check("ovf_running", 32'(bus.running), 32'h0);
      pulse(1, 0, 0);
      step(2);
      check("ovf_ignore_start", 32'(bus.running), 32'h0);
      check("ovf_ignore_live", 32'(bus.live), 32'h99);
`else
      check("ovf_live_wrap", 32'(bus.live), 32'h00);
      check("ovf_running", 32'(bus.running), 32'h1);
`endif

      // clear with simultaneous start_stop and lap edges while frozen at 0x42
      pulse(0, 0, 1);
      pulse(1, 0, 0);
      step(168);
      check("at42_live", 32'(bus.live), 32'h42);
      pulse(0, 1, 0);
      check("at42_disp", 32'(bus.disp), 32'h42);
      pulse(1, 1, 1);
      check("clr_disp",    32'(bus.disp),    32'h0);
      check("clr_live",    32'(bus.live),    32'h0);
      check("clr_running", 32'(bus.running), 32'h0);
      check("clr_frozen",  32'(bus.frozen),  32'h0);
      check("clr_ovf",     32'(bus.ovf),     32'h0);

      // asynchronous reset in the middle of a count
      pulse(1, 0, 0);
      step(10);
      pulse(0, 1, 0);
      step(3);
      #2 nrst = 1'b0;
      #1;
      check("areset_live",    32'(bus.live),    32'h0);
      check("areset_disp",    32'(bus.disp),    32'h0);
      check("areset_running", 32'(bus.running), 32'h0);
      check("areset_frozen",  32'(bus.frozen),  32'h0);
      @(negedge clk);
      nrst = 1'b1;
      step(2);

      // randomized button activity
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) bus.start_stop = ~bus.start_stop;
         if ($urandom_range(0, 11) == 0) bus.lap = ~bus.lap;
         bus.clear = ($urandom_range(0, 79) == 0);
         @(negedge clk);
      end
      bus.start_stop = 1'b0;
      bus.lap        = 1'b0;
      bus.clear      = 1'b0;
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lap_stopwatch.md
# lap_stopwatch

Parametrised BCD stopwatch with start/stop, lap-freeze and clear, for seven-segment display boards. Counts `DIGITS` cascaded decimal digits at a rate of one increment every `DIV` clock cycles, with a built-in prescaler. Presents a display value that can be frozen for a lap reading while the live count continues. Sits between the button debouncers and the per-digit hex segment decoders in the board top level.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits; legal range 1–8.
- `DIV`, 500000: clock cycles per count increment; `DIV >= 2`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `nrst`  in  1  reset; asynchronous, active-low.
- `start_stop`  in  1  debounced, synchronous level; each rising edge toggles run/stop.
- `lap`  in  1  debounced, synchronous level; each rising edge toggles display freeze.
- `clear`  in  1  debounced, synchronous level; while high, holds the count at zero.
- `disp`  out  4*DIGITS  BCD display value; digit 0 is the least significant, in `disp[3:0]`.
- `live`  out  4*DIGITS  BCD live count, never frozen.
- `running`  out  1  high in state RUN.
- `frozen`  out  1  high while `disp` holds a lap value.
- `ovf`  out  1  sticky flag: count has passed the all-9s value.

## Operation
- Edge detection:
  - The block registers `start_stop` and `lap` once.
  - A rising edge is input=1 while the registered copy=0.
  - `clear` is level-sensitive.
- State machine:
  - STOP (reset state): on a `start_stop` edge, go to RUN and clear the prescaler to 0.
  - RUN: on a `start_stop` edge, go to STOP; the prescaler value is discarded.
  - OVF: exists only with the macro defined (see Configuration). It ignores `start_stop` and leaves only on `clear` or reset.
- Prescaler:
  - Counts 0..DIV-1 in RUN only.
  - `tick` is asserted when the prescaler equals DIV-1 while in RUN; the prescaler then wraps to 0.
- Digit chain:
  - On `tick`, digit 0 increments.
  - A digit at 9 that receives a carry becomes 0 and carries to the next digit.
  - A carry out of the top digit is an overflow.
  - Digits never hold values 10–15.
- Lap:
  - On a `lap` edge with `frozen`=0: latch `live` into the lap register and set `frozen`.
  - On a `lap` edge with `frozen`=1: clear `frozen`.
  - `disp` = `frozen` ? lap register : `live`.
  - Lap edges are accepted in every state.
- Clear (highest priority):
  - Forces all digits, the prescaler, the lap register, `frozen` and `ovf` to 0.
  - State goes to STOP; any edge seen in the same cycle is ignored.
- Simultaneous edges: a `start_stop` edge and a `lap` edge in the same cycle are both applied.
- A `tick` coinciding with a `start_stop` edge in RUN still increments the count, then stops.
- Reset values:
  - `disp`, `live` and the lap register all 0.
  - `running`, `frozen`, `ovf` 0.
  - State STOP; edge registers 0.

## Timing
- An input edge sampled at clock edge k takes effect in state and outputs registered at edge k; outputs are visible after k.
- First increment: DIV cycles after the clock edge that accepts the start edge.
- Increment period thereafter: exactly DIV cycles in RUN.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Stop and restart: the partial prescaler count is lost, so the next increment comes a full DIV cycles after restart.
- Reset asserted mid-count: all state clears immediately, with no clock needed. Release is synchronous in effect: the first edge is evaluated on the first clock after `nrst` rises.

## Configuration
- `LAP_STOPWATCH_AUTOSTOP_EN` undefined:
  - Overflow wraps all digits to 0, sets `ovf`, and the count continues in RUN.
- `LAP_STOPWATCH_AUTOSTOP_EN` defined:
  - On the tick that would overflow, digits hold at all 9s, `ovf` sets, and the state moves to OVF with `running`=0.
  - `lap` still works in OVF.
  - `clear` returns to STOP.

## Test plan
Bench uses DIGITS=2, DIV=4.
- Reset, then one `start_stop` pulse, then 40 cycles → `live` reaches 0x10 at cycle 40; `running`=1.
- Run to 0x07, pulse `lap`, run 8 more cycles → `disp`=0x07, `live`=0x09; second `lap` pulse → `disp`=`live` on the next cycle.
- Run, then `start_stop` at prescaler=2 → `running`=0; restart → next increment exactly 4 cycles later.
- Count to 0x99, then one more tick:
  - Without the macro: `live`=0x00, `ovf`=1, `running`=1.
  - With the macro: `live`=0x99, `ovf`=1, `running`=0; a later `start_stop` has no effect.
- `clear` asserted with simultaneous `start_stop` and `lap` edges while at 0x42 frozen → all outputs 0, state STOP.
- `nrst` pulled low mid-count between clock edges → `live`, `disp` and flags go to 0 without a clock edge.
